// File: rtl/pwm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM sequencing controller slice:
//   - pwm_state_e : 2-bit controller state encoding as seen on the state port
//   - PWM_W       : default width of ARR/CCR values (generator counter width)
// ---------------------------------------------------------------------------
package pwm_ctrl_pkg;

    localparam int PWM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// ---------------------------------------------------------------------------
// pwm_period_timer
// Period down-counter that mirrors the PWM generator period. It counts from
// arr down to 1 and reloads arr on the cycle after reaching 1. While run is
// low the count is held at 0, so the first cycle with run high loads arr.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   run     : count enable; low holds the timer cleared
//   arr     : reload value, taken whenever a reload happens
//   tick    : high on the last cycle of each period (count == 1)
// ---------------------------------------------------------------------------
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int W = PWM_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         run,
    input  logic [W-1:0] arr,
    output logic         tick
);

    logic [W-1:0] count;

    // A count of 0 only occurs while stopped, so treating 0 like 1 makes
    // the first running cycle load the period value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (count <= W'(1)) begin
            count <= arr;
        end else begin
            count <= count - W'(1);
        end
    end

    assign tick = (count == W'(1));

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_ramp_ctrl
// Sequencing controller for one PWM generator channel. Soft-starts the duty
// from 0 to a target compare value, applies run-time ARR/CCR updates only on
// period boundaries, and ramps the duty back to 0 before disabling.
// Optional feature macro: PWM_RAMP_CTRL_SOFTSTART_EN
//   defined   : stepped ramps using cfg_step / cfg_div
//   undefined : ramp-up and ramp-down each take a single period
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   start, stop             : single-cycle control pulses (stop wins)
//   cfg_arr/ccr/step/div    : ramp configuration, sampled on start from IDLE
//   upd_valid/ready/arr/ccr : run-time update handshake (RUN only)
//   pwm_gen_en              : generator enable
//   counter_arr/ccr         : generator ARR / CCR
//   period_tick             : last cycle of each period
//   ramp_done, stop_done    : pulses on entering RUN / IDLE
//   state                   : 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
// ---------------------------------------------------------------------------
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int W     = PWM_W,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [W-1:0]     cfg_arr,
    input  logic [W-1:0]     cfg_ccr,
    input  logic [W-1:0]     cfg_step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [W-1:0]     upd_arr,
    input  logic [W-1:0]     upd_ccr,
    output logic             pwm_gen_en,
    output logic [W-1:0]     counter_arr,
    output logic [W-1:0]     counter_ccr,
    output logic             period_tick,
    output logic             ramp_done,
    output logic             stop_done,
    output logic [1:0]       state
);

    pwm_state_e   state_q, state_d;
    logic         en_d, upd_ready_d, ramp_done_d, stop_done_d;
    logic [W-1:0] arr_d, ccr_d, target, target_d;
    logic         pend, pend_d;
    logic [W-1:0] pend_arr, pend_arr_d, pend_ccr, pend_ccr_d;
    logic         tick, step_hit;
    logic [W-1:0] up_val, dn_val;

    // ARR of 0 would stall the generator, so it is forced to 1, and the
    // compare value may never exceed the period.
    logic [W-1:0] cfg_arr_eff, cfg_tgt, upd_arr_eff, upd_tgt;
    assign cfg_arr_eff = (cfg_arr == '0) ? W'(1) : cfg_arr;
    assign cfg_tgt     = (cfg_ccr > cfg_arr_eff) ? cfg_arr_eff : cfg_ccr;
    assign upd_arr_eff = (upd_arr == '0) ? W'(1) : upd_arr;
    assign upd_tgt     = (upd_ccr > upd_arr_eff) ? upd_arr_eff : upd_ccr;

`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    logic [W-1:0]     step_r, step_d, step_eff;
    logic [DIV_W-1:0] div_r, div_d, div_cnt, div_cnt_d;
    logic [W:0]       up_sum;

    // A zero step would never reach the target, so it means one full jump.
    assign step_eff = (step_r == '0) ? target : step_r;
    assign step_hit = tick && (div_cnt == div_r);
    assign up_sum   = {1'b0, counter_ccr} + {1'b0, step_eff};
    assign up_val   = (up_sum > {1'b0, target}) ? target : up_sum[W-1:0];
    assign dn_val   = ((step_eff == '0) || (counter_ccr <= step_eff)) ?
                      '0 : (counter_ccr - step_eff);
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_step, cfg_div};
    assign step_hit   = tick;
    assign up_val     = target;
    assign dn_val     = '0;
`endif

    // Timer is driven from next-state values so it loads the new period on
    // the same edge the generator sees it.
    pwm_period_timer #(.W(W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (en_d),
        .arr     (arr_d),
        .tick    (tick)
    );

    assign period_tick = tick;
    assign state       = state_q;

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pwm_gen_en  <= 1'b0;
            counter_arr <= '0;
            counter_ccr <= '0;
            target      <= '0;
            pend        <= 1'b0;
            pend_arr    <= '0;
            pend_ccr    <= '0;
            upd_ready   <= 1'b0;
            ramp_done   <= 1'b0;
            stop_done   <= 1'b0;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
            step_r      <= '0;
            div_r       <= '0;
            div_cnt     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pwm_gen_en  <= en_d;
            counter_arr <= arr_d;
            counter_ccr <= ccr_d;
            target      <= target_d;
            pend        <= pend_d;
            pend_arr    <= pend_arr_d;
            pend_ccr    <= pend_ccr_d;
            upd_ready   <= upd_ready_d;
            ramp_done   <= ramp_done_d;
            stop_done   <= stop_done_d;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
            step_r      <= step_d;
            div_r       <= div_d;
            div_cnt     <= div_cnt_d;
`endif
        end
    end

    // Next-state logic. stop always has priority over start; updates are
    // staged in pend_* and only copied out on a period boundary.
    always_comb begin
        state_d     = state_q;
        en_d        = pwm_gen_en;
        arr_d       = counter_arr;
        ccr_d       = counter_ccr;
        target_d    = target;
        pend_d      = pend;
        pend_arr_d  = pend_arr;
        pend_ccr_d  = pend_ccr;
        ramp_done_d = 1'b0;
        stop_done_d = 1'b0;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        step_d      = step_r;
        div_d       = div_r;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_RAMP_UP;
                    en_d     = 1'b1;
                    ccr_d    = '0;
                    arr_d    = cfg_arr_eff;
                    target_d = cfg_tgt;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
                    step_d   = cfg_step;
                    div_d    = cfg_div;
`endif
                end
            end
            ST_RAMP_UP: begin
                if (stop) begin
                    state_d = ST_RAMP_DOWN;
                end else if (step_hit) begin
                    ccr_d = up_val;
                    if (up_val == target) begin
                        state_d     = ST_RUN;
                        ramp_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_RAMP_DOWN;
                    pend_d  = 1'b0;
                end else begin
                    if (pend && tick) begin
                        arr_d    = pend_arr;
                        ccr_d    = pend_ccr;
                        target_d = pend_ccr;
                        pend_d   = 1'b0;
                    end
                    if (upd_valid && upd_ready) begin
                        pend_d     = 1'b1;
                        pend_arr_d = upd_arr_eff;
                        pend_ccr_d = upd_tgt;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (start && !stop) begin
                    state_d = ST_RAMP_UP;
                end else if (step_hit) begin
                    ccr_d = dn_val;
                    if (dn_val == '0) begin
                        state_d     = ST_IDLE;
                        en_d        = 1'b0;
                        stop_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        upd_ready_d = (state_d == ST_RUN) && !pend_d;
    end

`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    // Every state change restarts the divider, which covers start, stop,
    // restart from ramp-down and ramp completion in one rule.
    always_comb begin
        div_cnt_d = div_cnt;
        if (state_d != state_q) begin
            div_cnt_d = '0;
        end else if (tick && (state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN)) begin
            div_cnt_d = step_hit ? '0 : div_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
// Self-checking bench for pwm_ramp_ctrl. Stimulus tasks push the expected
// sequence of visible changes (counter_ccr, state, enable, ARR, done pulses
// and the cycle they occur on) into a scoreboard; a monitor pops and compares
// whenever the DUT outputs change. Works with or without
// PWM_RAMP_CTRL_SOFTSTART_EN.
// ---------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int W     = 32;
    localparam int DIV_W = 8;
    localparam longint S_IDLE = 0, S_UP = 1, S_RUN = 2, S_DOWN = 3;
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start, stop, upd_valid;
    logic [W-1:0]     cfg_arr, cfg_ccr, cfg_step, upd_arr, upd_ccr;
    logic [DIV_W-1:0] cfg_div;
    logic             upd_ready, pwm_gen_en, period_tick, ramp_done, stop_done;
    logic [W-1:0]     counter_arr, counter_ccr;
    logic [1:0]       state;

    pwm_ramp_ctrl #(.W(W), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .cfg_arr(cfg_arr), .cfg_ccr(cfg_ccr), .cfg_step(cfg_step), .cfg_div(cfg_div),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_arr(upd_arr), .upd_ccr(upd_ccr),
        .pwm_gen_en(pwm_gen_en), .counter_arr(counter_arr), .counter_ccr(counter_ccr),
        .period_tick(period_tick), .ramp_done(ramp_done), .stop_done(stop_done),
        .state(state)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint ccr; longint st; longint en; longint arr;
        longint rd;  longint sd; longint t;
    } ev_t;
    ev_t sb[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Model of the configuration and period phase the DUT should be in.
    longint m_c, m_tgt, m_step, m_div, cur_arr = 1, phase_base = 0, last_b;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint next_b(input longint after);
        return phase_base + ((after - phase_base) / cur_arr + 1) * cur_arr;
    endfunction

    function automatic longint eff_div();
        return SOFT ? m_div : 0;
    endfunction

    function automatic longint step_eff();
        return (m_step == 0) ? m_tgt : m_step;
    endfunction

    task automatic push_ev(input longint c, input longint st, input longint en,
                           input longint rd, input longint sd, input longint t);
        ev_t e;
        e.ccr = c; e.st = st; e.en = en; e.arr = cur_arr; e.rd = rd; e.sd = sd; e.t = t;
        sb.push_back(e);
    endtask

    task automatic model_up(input longint ref_t);
        longint t, c_new;
        bit done = 1'b0;
        t = next_b(ref_t) + eff_div() * cur_arr;
        while (!done) begin
            if (SOFT) c_new = (m_c + step_eff() > m_tgt) ? m_tgt : m_c + step_eff();
            else      c_new = m_tgt;
            done = (c_new == m_tgt);
            push_ev(c_new, done ? S_RUN : S_UP, 1, done, 0, t);
            m_c = c_new;
            t += (eff_div() + 1) * cur_arr;
        end
    endtask

    task automatic model_down(input longint ref_t, input int max_steps);
        longint t, c_new;
        bit idle;
        t = next_b(ref_t) + eff_div() * cur_arr;
        for (int k = 0; k < max_steps; k++) begin
            if (SOFT) c_new = (m_c > step_eff()) ? m_c - step_eff() : 0;
            else      c_new = 0;
            idle = (c_new == 0);
            push_ev(c_new, idle ? S_IDLE : S_DOWN, idle ? 0 : 1, 0, idle, t);
            m_c = c_new;
            if (idle) break;
            t += (eff_div() + 1) * cur_arr;
        end
    endtask

    // Monitor: any visible change or done pulse must match the next entry.
    logic [W+W+2:0] prev_sig = '0, cur_sig;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_sig = '0;
        end else begin
            cur_sig = {state, pwm_gen_en, counter_arr, counter_ccr};
            if (cur_sig != prev_sig || ramp_done || stop_done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_event", {ramp_done, stop_done, cur_sig != prev_sig}, 0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    check_output("ev_ccr",   counter_ccr, e.ccr);
                    check_output("ev_state", state,       e.st);
                    check_output("ev_en",    pwm_gen_en,  e.en);
                    check_output("ev_arr",   counter_arr, e.arr);
                    check_output("ev_ramp_done", ramp_done, e.rd);
                    check_output("ev_stop_done", stop_done, e.sd);
                    check_output("ev_cycle", cyc, e.t);
                end
            end
            prev_sig = cur_sig;
        end
    end

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_output({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        #1;
    endtask

    task automatic wait_cyc(input longint n);
        int g = 0;
        while (cyc < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
    endtask

    function automatic bit on_boundary(input longint e, input int want_off);
        longint off = (e - phase_base) % cur_arr;
        if (want_off >= 0) return off != want_off;
        return off == 0;
    endfunction

    task automatic apply_stimulus_start(input longint arr, input longint ccr,
                                        input longint step, input longint div);
        longint e;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_arr = W'(arr); cfg_ccr = W'(ccr); cfg_step = W'(step); cfg_div = DIV_W'(div);
        e = cyc + 1;
        cur_arr = (arr == 0) ? 1 : arr;
        m_tgt = (ccr > cur_arr) ? cur_arr : ccr;
        m_step = step; m_div = div; m_c = 0; phase_base = e;
        push_ev(0, S_UP, 1, 0, 0, e);
        model_up(e);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_arr = '1; cfg_ccr = '1; cfg_step = '1; cfg_div = '1;
    endtask

    task automatic apply_stimulus_stop(input bit with_start, input int max_steps, input int want_off);
        longint e;
        @(posedge clk); #1;
        while (on_boundary(cyc + 1, want_off)) begin
            @(posedge clk); #1;
        end
        stop = 1'b1;
        start = with_start;
        e = cyc + 1;
        push_ev(m_c, S_DOWN, 1, 0, 0, e);
        model_down(e, max_steps);
        @(posedge clk); #1;
        stop = 1'b0;
        start = 1'b0;
    endtask

    task automatic apply_stimulus_restart();
        longint e;
        @(posedge clk); #1;
        while (on_boundary(cyc + 1, -1)) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        e = cyc + 1;
        push_ev(m_c, S_UP, 1, 0, 0, e);
        model_up(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic apply_stimulus_update(input longint arr, input longint ccr);
        longint e, b;
        @(posedge clk); #1;
        check_output("upd_ready_pre", upd_ready, 1);
        upd_valid = 1'b1;
        upd_arr = W'(arr); upd_ccr = W'(ccr);
        e = cyc + 1;
        b = next_b(e);
        cur_arr = (arr == 0) ? 1 : arr;
        m_c = (ccr > cur_arr) ? cur_arr : ccr;
        m_tgt = m_c;
        push_ev(m_c, S_RUN, 1, 0, 0, b);
        phase_base = b;
        last_b = b;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        upd_arr = '0; upd_ccr = '0;
        check_output("upd_ready_pending", upd_ready, 0);
    endtask

    task automatic pulse_ignored(input bit s, input bit p);
        @(posedge clk); #1;
        start = s; stop = p;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_en"},        pwm_gen_en,  0);
        check_output({tag, "_arr"},       counter_arr, 0);
        check_output({tag, "_ccr"},       counter_ccr, 0);
        check_output({tag, "_upd_ready"}, upd_ready,   0);
        check_output({tag, "_tick"},      period_tick, 0);
        check_output({tag, "_ramp_done"}, ramp_done,   0);
        check_output({tag, "_stop_done"}, stop_done,   0);
        check_output({tag, "_state"},     state,       S_IDLE);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; upd_valid = 1'b0;
        cfg_arr = '0; cfg_ccr = '0; cfg_step = '0; cfg_div = '0;
        upd_arr = '0; upd_ccr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Basic ramp, then boundary-aligned update and ramp-down.
        apply_stimulus_start(10, 6, 2, 0);
        check_output("upd_ready_in_ramp", upd_ready, 0);
        wait_drain("ramp_basic");
        check_output("upd_ready_run", upd_ready, 1);
        apply_stimulus_update(20, 5);
        wait_drain("update");
        check_output("upd_ready_after_apply", upd_ready, 1);
        wait_cyc(last_b + 18);
        check_output("tick_early", period_tick, 0);
        wait_cyc(last_b + 19);
        check_output("tick_new_period", period_tick, 1);
        apply_stimulus_stop(1'b0, 100, -1);
        wait_drain("stop_basic");
        check_output("en_after_stop", pwm_gen_en, 0);

        // Clamped target, restart during ramp-down, simultaneous start/stop.
        apply_stimulus_start(8, 20, 3, 1);
        wait_drain("ramp_clamp");
`ifdef PWM_RAMP_CTRL_SOFTSTART_EN
        apply_stimulus_stop(1'b0, 1, -1);
        wait_drain("stop_partial");
`else
        apply_stimulus_stop(1'b0, 0, 1);
        repeat (2) @(posedge clk);
`endif
        apply_stimulus_restart();
        wait_drain("restart");
        apply_stimulus_stop(1'b1, 100, -1);
        wait_drain("start_stop_same");

        // Zero target, ignored start in RUN, ignored stop in IDLE.
        apply_stimulus_start(5, 0, 4, 0);
        wait_drain("zero_target");
        pulse_ignored(1'b1, 1'b0);
        apply_stimulus_stop(1'b0, 100, -1);
        wait_drain("zero_stop");
        pulse_ignored(1'b0, 1'b1);

        // ARR of 0 forced to 1 with zero step, then update on a 1-cycle period.
        apply_stimulus_start(0, 3, 0, 0);
        wait_drain("arr_zero");
        @(negedge clk);
        check_output("tick_arr1", period_tick, 1);
        apply_stimulus_update(3, 7);
        wait_drain("update_clamp");
        apply_stimulus_stop(1'b0, 100, -1);
        wait_drain("stop_arr3");

        // Asynchronous reset in the middle of RUN.
        apply_stimulus_start(10, 6, 2, 0);
        wait_drain("ramp_before_reset");
        check_output("sb_empty", sb.size(), 0);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_output("state_after_release", state, S_IDLE);
        check_output("ccr_after_release", counter_ccr, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencing controller for the PWM generator. It drives the generator's enable, auto-reload (ARR) and compare (CCR) inputs. It soft-starts the duty cycle from 0 to a target compare value in fixed steps. It applies run-time ARR/CCR updates only on period boundaries, so no partial period ever occurs. It ramps the duty back to 0 before disabling. It sits between the processor-side register block and the PWM generator instance, one controller per PWM channel.

## Interface
Parameters:
- W, 32, width of ARR/CCR values; matches the generator's counter width.
- DIV_W, 8, width of the periods-per-step divider.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins the ramp-up from IDLE or RAMP_DOWN.
- stop  in  1  single-cycle pulse; begins the ramp-down from RAMP_UP or RUN.
- cfg_arr  in  W  period in clk cycles, sampled on an accepted start.
- cfg_ccr  in  W  target compare value, sampled on an accepted start.
- cfg_step  in  W  CCR increment/decrement per step, sampled on an accepted start.
- cfg_div  in  DIV_W  periods per step minus 1, sampled on an accepted start.
- upd_valid  in  1  run-time update request.
- upd_ready  out  1  update can be accepted.
- upd_arr  in  W  new ARR for a run-time update.
- upd_ccr  in  W  new CCR for a run-time update.
- pwm_gen_en  out  1  to the generator enable input.
- counter_arr  out  W  to the generator ARR input.
- counter_ccr  out  W  to the generator CCR input.
- period_tick  out  1  one-cycle pulse on the last cycle of each period.
- ramp_done  out  1  one-cycle pulse when RUN is entered.
- stop_done  out  1  one-cycle pulse when IDLE is re-entered.
- state  out  2  current state: 0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN.

## Operation
- State machine: IDLE -> RAMP_UP -> RUN -> RAMP_DOWN -> IDLE.
- IDLE behaviour:
  - pwm_gen_en=0 and counter_ccr=0.
  - counter_arr holds the last shadow ARR (0 after reset).
  - The period timer is held.
- start in IDLE:
  - Latch cfg_*. The effective ARR is max(cfg_arr,1). The target is min(cfg_ccr, effective ARR).
  - Next cycle: pwm_gen_en=1, counter_ccr=0, state=RAMP_UP, and the period timer is loaded with ARR.
- Period timer:
  - Counts down from ARR to 1 and reloads ARR on the cycle after it reaches 1.
  - period_tick is high while the count equals 1.
- Step divider: counts period_ticks. Each (cfg_div+1)-th tick is a step.
- RAMP_UP step: counter_ccr = min(counter_ccr + step, target); the sum is computed in W+1 bits. When the result equals the target: state=RUN and ramp_done pulses.
- RAMP_DOWN step: counter_ccr = max(counter_ccr - step, 0). When the result is 0: pwm_gen_en=0, state=IDLE and stop_done pulses.
- cfg_step=0 is treated as step = target, i.e. a single-step ramp.
- RUN behaviour:
  - upd_ready=1 when no update is pending.
  - An update is accepted when upd_valid && upd_ready; the values go to the shadow ARR/CCR with the same clamping rules.
  - Both values reach counter_arr/counter_ccr together, on the cycle after the next period_tick. The period timer reloads with the new ARR.
  - upd_ready=0 while an update is pending and in every state other than RUN.
- stop in RAMP_UP or RUN:
  - state=RAMP_DOWN immediately.
  - Any pending update is discarded and the divider is cleared.
- start in RAMP_DOWN: state=RAMP_UP, continuing from the current counter_ccr with the latched configuration. cfg_* is not resampled.
- start in RAMP_UP or RUN, and stop in IDLE or RAMP_DOWN, are ignored.
- start and stop in the same cycle: stop wins, and start is ignored.
- Target of 0 on start: enter RAMP_UP, then go to RUN at the first step with counter_ccr=0.

## Timing
- Reset values: pwm_gen_en=0, counter_arr=0, counter_ccr=0, upd_ready=0, period_tick=0, ramp_done=0, stop_done=0, state=IDLE. All counters and shadows are 0.
- All outputs are registered.
- start to pwm_gen_en=1: 1 cycle.
- Step to counter_ccr change: the cycle after the qualifying period_tick.
- Accepted update to applied: at most ARR+1 cycles.
- Assertion of reset_n mid-operation returns everything to reset values asynchronously. The generator output goes low through its own reset.

## Configuration
- PWM_RAMP_CTRL_SOFTSTART_EN defined: ramp-up and ramp-down operate as described.
- Macro undefined:
  - cfg_step and cfg_div are ignored, and the divider and step logic are not built.
  - RAMP_UP lasts exactly one period: at the first period_tick, counter_ccr=target, state=RUN and ramp_done pulses.
  - RAMP_DOWN drops pwm_gen_en and enters IDLE at the next period_tick, with counter_ccr=0 and a stop_done pulse.

## Structure
- Shared package pwm_ctrl_pkg holds:
  - the 2-bit state encoding constants (ST_IDLE, ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN);
  - the default W.
- One sub-module, pwm_period_timer, contains the down-counter, reload and period_tick. Its ports are clk, reset_n, run, arr, tick.
- The state machine, divider, saturating step arithmetic and shadow registers live in the top module.

## Test plan
- Reset check: reset_n low mid-RUN -> all outputs return to reset values in the same cycle; state=0 after release.
- Basic ramp-up: arr=10, ccr=6, step=2, div=0, start -> counter_ccr goes 0→2→4→6, changing every 10 cycles; ramp_done pulses with the 6; state=RUN.
- Clamping and saturation: arr=8, ccr=20, step=3 -> target clamped to 8; the sequence is 0,3,6,8; ramp_done pulses once.
- Boundary-aligned update: in RUN, upd_arr=20, upd_ccr=5 accepted mid-period -> counter_arr and counter_ccr change together, one cycle after period_tick; the next tick comes 20 cycles later; upd_ready is 0 in between.
- Stop, restart and simultaneous events:
  - stop in RUN at ccr=6, step=2 -> 4,2,0; then pwm_gen_en=0 and stop_done pulses.
  - start during RAMP_DOWN at 4 -> ramp resumes upward from 4.
  - start and stop in the same cycle -> stop taken.
- Macro undefined: start with arr=10, ccr=6 -> counter_ccr=6 after the first period_tick; stop -> pwm_gen_en=0 after the next period_tick.
